sequenciador_de_instrucoes: RTL and testbench
=============================================

Name: sequenciador_de_instrucoes

Overview:
- Multi-cycle control FSM for the 16-bit, 8-register, accumulator-A / result-register-G datapath.
- Accepts one instruction word over a valid/ready handshake and latches it into an internal IR.
- Drives the register write enables, bus source select, A/G enables and ALU op step by step until the instruction retires.
- Sits between the instruction source and the datapath register file / ALU; replaces the free-running step counter with a handshaked sequencer.

Parameters:
- INSTR_W, 16, instruction width; only 16 is supported.
- HALT_EN, 1, when 1 opcode 111 halts the sequencer; when 0 opcode 111 executes as NOP.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- instr  input  16  instruction word: [15:13] op, [12:10] rx, [9:7] ry. Imm10 = [9:0], sign-extended by the datapath.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- reg_enable  output  8  one-hot write enable for R0..R7.
- bus_sel  output  4  bus source: 0-7 = Rn, 8 = IMM, 9 = G, 15 = none/idle.
- a_enable  output  1  load A from bus.
- g_enable  output  1  load G from ALU.
- alu_op  output  2  00 add, 01 sub, 10 and, 11 or.
- done  output  1  one-cycle pulse in the final step of an instruction.
- busy  output  1  high in any non-IDLE state.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE and IR is cleared to 0.
  - All enables and done are 0; bus_sel=15, alu_op=00, busy=0, halted=0.
  - instr_ready=1 once resetn deasserts.
- States: IDLE, T1, T2, T3, HALT. Outputs are combinational from state and IR; no output depends on instr except through IR.
- IDLE:
  - instr_ready=1; all other controls are inactive.
  - On a rising edge with instr_valid=1, IR <= instr and state goes to T1. Otherwise stay in IDLE.
- Opcodes and step sequences:
  - 000 mv rx,ry: T1 drives bus_sel=ry, reg_enable[rx]=1, done=1, then returns to IDLE.
  - 001 mvi rx,#imm: T1 drives bus_sel=8, reg_enable[rx]=1, done=1, then returns to IDLE.
  - 010 add, 011 sub, 100 and, 101 or (rx <= rx op ry):
    - T1: bus_sel=rx, a_enable=1.
    - T2: bus_sel=ry, g_enable=1, alu_op = op-2 (010→00, 011→01, 100→10, 101→11).
    - T3: bus_sel=9, reg_enable[rx]=1, done=1, then returns to IDLE.
  - 110 nop: T1 drives done=1 with no enables, then returns to IDLE.
  - 111 halt (HALT_EN=1): T1 drives done=1, then goes to HALT. With HALT_EN=0 it behaves exactly as nop.
- HALT: instr_ready=0, halted=1, all enables 0. Only resetn exits this state.
- Latency and throughput:
  - If accepted at edge k, the first step is the cycle after edge k.
  - mv/mvi/nop: instr_ready returns 2 cycles after acceptance.
  - ALU ops: instr_ready returns 4 cycles after acceptance.
  - Acceptance never overlaps execution.
- Invariants:
  - At most one reg_enable bit is set in any cycle.
  - a_enable, g_enable and any reg_enable bit are never high in the same cycle.
- Boundary conditions:
  - rx==ry is legal. add r3,r3 doubles r3 because A and G are sampled in separate steps.
  - instr_valid high while busy is ignored and IR is unchanged; the source must hold instr until a ready&valid edge.
  - resetn low mid-instruction aborts it in the same cycle with no further enables. A partially completed ALU op leaves rx unwritten.
  - done never asserts in IDLE or HALT.

Test Plan:
- Reset then mvi r2,#-5 (instr=16'h2BFB, valid one cycle) -> T1: bus_sel=8, reg_enable=8'h04, done=1; instr_ready=1 on the next cycle; datapath R2=16'hFFFB.
- mv r5,r2 right after mvi r2 -> T1: bus_sel=2, reg_enable=8'h20, done=1; R5=16'hFFFB.
- add r1,r1 with R1=7 (instr=16'h4480) -> T1 bus_sel=1 a_enable; T2 bus_sel=1 g_enable alu_op=00; T3 bus_sel=9 reg_enable=8'h02 done; R1=14; busy high for exactly 3 cycles.
- sub r0,r4 with instr_valid held high through all steps, then a new mv presented -> the second instruction is accepted only on the first IDLE edge; each instruction produces exactly one done.
- halt (instr=16'hE000), HALT_EN=1 -> done pulse, then halted=1, instr_ready=0 forever despite instr_valid=1. Repeat with HALT_EN=0 -> acts as nop and instr_ready returns.
- resetn pulsed low during T2 of an and -> all enables drop immediately, state is IDLE, IR=0, rx is never written, and a subsequent mvi executes normally.

Source files
------------

// File: rtl/sequenciador_de_instrucoes.sv
// Handshaked multi-cycle control sequencer for the accumulator datapath.
// One instruction is latched into IR and stepped through T1..T3 until it retires.
module sequenciador_de_instrucoes #(
    parameter int INSTR_W = 16,
    parameter bit HALT_EN = 1'b1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [7:0]         reg_enable,
    output logic [3:0]         bus_sel,
    output logic               a_enable,
    output logic               g_enable,
    output logic [1:0]         alu_op,
    output logic               done,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_HALT
    } state_t;

    localparam logic [3:0] BUS_IMM  = 4'd8;
    localparam logic [3:0] BUS_G    = 4'd9;
    localparam logic [3:0] BUS_NONE = 4'd15;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] alu_sel;
    logic       unused_ir;

    assign op        = ir_q[15:13];
    assign rx        = ir_q[12:10];
    assign ry        = ir_q[9:7];
    // ALU opcodes 010..101 map onto alu_op 00..11
    assign alu_sel   = op - 3'd2;
    // Immediate bits are consumed by the datapath, not here
    assign unused_ir = ^ir_q[6:0];

    // State and instruction register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and per-step control outputs
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        instr_ready = 1'b0;
        reg_enable  = 8'h00;
        bus_sel     = BUS_NONE;
        a_enable    = 1'b0;
        g_enable    = 1'b0;
        alu_op      = 2'b00;
        done        = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                instr_ready = resetn;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                busy = 1'b1;
                case (op)
                    3'b000: begin
                        bus_sel    = {1'b0, ry};
                        reg_enable = 8'd1 << rx;
                        done       = 1'b1;
                        state_d    = S_IDLE;
                    end
                    3'b001: begin
                        bus_sel    = BUS_IMM;
                        reg_enable = 8'd1 << rx;
                        done       = 1'b1;
                        state_d    = S_IDLE;
                    end
                    3'b110: begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    3'b111: begin
                        done    = 1'b1;
                        state_d = HALT_EN ? S_HALT : S_IDLE;
                    end
                    default: begin
                        bus_sel  = {1'b0, rx};
                        a_enable = 1'b1;
                        state_d  = S_T2;
                    end
                endcase
            end
            S_T2: begin
                busy     = 1'b1;
                bus_sel  = {1'b0, ry};
                g_enable = 1'b1;
                alu_op   = alu_sel[1:0];
                state_d  = S_T3;
            end
            S_T3: begin
                busy       = 1'b1;
                bus_sel    = BUS_G;
                reg_enable = 8'd1 << rx;
                done       = 1'b1;
                state_d    = S_IDLE;
            end
            S_HALT: begin
                busy   = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequenciador_de_instrucoes.sv
// Bench for the instruction sequencer: two instances (halt on / halt off),
// a step-list reference model and a small register-file datapath.
module tb_sequenciador_de_instrucoes;

    typedef struct packed {
        logic       ready;
        logic [7:0] reg_en;
        logic [3:0] bus;
        logic       a;
        logic       g;
        logic [1:0] alu;
        logic       done;
        logic       busy;
        logic       halted;
    } ctl_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;

    logic       rdy [2];
    logic [7:0] ren [2];
    logic [3:0] bsel [2];
    logic       aen [2];
    logic       gen [2];
    logic [1:0] aop [2];
    logic       dne [2];
    logic       bsy [2];
    logic       hlt [2];

    int total = 0;
    int bad = 0;

    ctl_t        mq [2][$];
    logic        m_halted [2];
    logic        halt_arm [2];
    logic        accepted;
    logic [15:0] exec_instr;
    logic [15:0] dp_r [8];
    logic [15:0] exp_r [8];
    logic [15:0] dp_a;
    logic [15:0] dp_g;

    sequenciador_de_instrucoes #(.INSTR_W(16), .HALT_EN(1'b0)) u0 (
        .clock(clock), .resetn(resetn), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(rdy[0]),
        .reg_enable(ren[0]), .bus_sel(bsel[0]), .a_enable(aen[0]),
        .g_enable(gen[0]), .alu_op(aop[0]), .done(dne[0]),
        .busy(bsy[0]), .halted(hlt[0])
    );

    sequenciador_de_instrucoes #(.INSTR_W(16), .HALT_EN(1'b1)) u1 (
        .clock(clock), .resetn(resetn), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(rdy[1]),
        .reg_enable(ren[1]), .bus_sel(bsel[1]), .a_enable(aen[1]),
        .g_enable(gen[1]), .alu_op(aop[1]), .done(dne[1]),
        .busy(bsy[1]), .halted(hlt[1])
    );

    initial forever #5 clock = ~clock;

    function automatic ctl_t obs(int d);
        ctl_t c;
        c.ready  = rdy[d];
        c.reg_en = ren[d];
        c.bus    = bsel[d];
        c.a      = aen[d];
        c.g      = gen[d];
        c.alu    = aop[d];
        c.done   = dne[d];
        c.busy   = bsy[d];
        c.halted = hlt[d];
        return c;
    endfunction

    function automatic ctl_t mk(logic [7:0] re, logic [3:0] bus,
                                logic a, logic g, logic [1:0] alu,
                                logic dn);
        ctl_t c;
        c.ready  = 1'b0;
        c.reg_en = re;
        c.bus    = bus;
        c.a      = a;
        c.g      = g;
        c.alu    = alu;
        c.done   = dn;
        c.busy   = 1'b1;
        c.halted = 1'b0;
        return c;
    endfunction

    function automatic ctl_t quiet(logic rd, logic bz, logic hl);
        ctl_t c;
        c = mk(8'h00, 4'd15, 1'b0, 1'b0, 2'b00, 1'b0);
        c.ready  = rd;
        c.busy   = bz;
        c.halted = hl;
        return c;
    endfunction

    function automatic ctl_t expect_now(int d);
        if (mq[d].size() > 0) return mq[d][0];
        if (m_halted[d]) return quiet(1'b0, 1'b1, 1'b1);
        return quiet(1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] sext(logic [15:0] ins);
        return {{6{ins[9]}}, ins[9:0]};
    endfunction

    // The step list an instruction should produce, straight from the opcode table
    task automatic push_steps(int d, logic [15:0] ins);
        int op, rx, ry;
        logic [7:0] oh;
        op = int'(ins[15:13]);
        rx = int'(ins[12:10]);
        ry = int'(ins[9:7]);
        oh = 8'd1 << rx;
        if (op == 0) begin
            mq[d].push_back(mk(oh, 4'(ry), 1'b0, 1'b0, 2'b00, 1'b1));
        end else if (op == 1) begin
            mq[d].push_back(mk(oh, 4'd8, 1'b0, 1'b0, 2'b00, 1'b1));
        end else if (op >= 6) begin
            mq[d].push_back(mk(8'h00, 4'd15, 1'b0, 1'b0, 2'b00, 1'b1));
            halt_arm[d] = (op == 7) && (d == 1);
        end else begin
            mq[d].push_back(mk(8'h00, 4'(rx), 1'b1, 1'b0, 2'b00, 1'b0));
            mq[d].push_back(mk(8'h00, 4'(ry), 1'b0, 1'b1, 2'(op - 2), 1'b0));
            mq[d].push_back(mk(oh, 4'd9, 1'b0, 1'b0, 2'b00, 1'b1));
        end
    endtask

    // Architectural effect of a retired instruction
    task automatic retire(logic [15:0] ins);
        int rx, ry;
        rx = int'(ins[12:10]);
        ry = int'(ins[9:7]);
        case (ins[15:13])
            3'd0: exp_r[rx] = exp_r[ry];
            3'd1: exp_r[rx] = sext(ins);
            3'd2: exp_r[rx] = exp_r[rx] + exp_r[ry];
            3'd3: exp_r[rx] = exp_r[rx] - exp_r[ry];
            3'd4: exp_r[rx] = exp_r[rx] & exp_r[ry];
            3'd5: exp_r[rx] = exp_r[rx] | exp_r[ry];
            default: ;
        endcase
    endtask

    task automatic tick();
        ctl_t c, o1, e;
        logic [15:0] busv;
        logic chk;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            e = expect_now(d);
            total++;
            assert (obs(d) === e) else begin
                bad++;
                $error("FAIL ctl dut%0d observed=%h expected=%h", d, obs(d), e);
            end
        end
        o1 = obs(1);
        if (o1.bus < 4'd8) busv = dp_r[o1.bus[2:0]];
        else if (o1.bus == 4'd8) busv = sext(exec_instr);
        else if (o1.bus == 4'd9) busv = dp_g;
        else busv = 16'h0000;
        @(posedge clock);
        if (o1.g) begin
            case (o1.alu)
                2'd0: dp_g = dp_a + busv;
                2'd1: dp_g = dp_a - busv;
                2'd2: dp_g = dp_a & busv;
                default: dp_g = dp_a | busv;
            endcase
        end
        if (o1.a) dp_a = busv;
        for (int i = 0; i < 8; i++) if (o1.reg_en[i]) dp_r[i] = busv;
        accepted = 1'b0;
        chk = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (mq[d].size() > 0) begin
                c = mq[d].pop_front();
                if (c.done && d == 1) begin
                    retire(exec_instr);
                    chk = 1'b1;
                end
                if (mq[d].size() == 0) begin
                    m_halted[d] = halt_arm[d];
                    halt_arm[d] = 1'b0;
                end
            end else if (!m_halted[d] && instr_valid) begin
                push_steps(d, instr);
                if (d == 1) exec_instr = instr;
                if (d == 0) accepted = 1'b1;
            end
        end
        if (chk) begin
            total++;
            assert (dp_r === exp_r) else begin
                bad++;
                $error("FAIL regfile observed r0..r7=%h %h %h %h %h %h %h %h expected=%h %h %h %h %h %h %h %h",
                       dp_r[0], dp_r[1], dp_r[2], dp_r[3], dp_r[4], dp_r[5], dp_r[6], dp_r[7],
                       exp_r[0], exp_r[1], exp_r[2], exp_r[3], exp_r[4], exp_r[5], exp_r[6], exp_r[7]);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        ctl_t z;
        z = quiet(1'b0, 1'b0, 1'b0);
        instr_valid = 1'b0;
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            assert (obs(d) === z) else begin
                bad++;
                $error("FAIL in_reset dut%0d observed=%h expected=%h", d, obs(d), z);
            end
            mq[d].delete();
            m_halted[d] = 1'b0;
            halt_arm[d] = 1'b0;
        end
        total++;
        assert (u1.ir_q === 16'h0000) else begin
            bad++;
            $error("FAIL ir_clear observed=%h expected=0000", u1.ir_q);
        end
        @(negedge clock);
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic run1(logic [15:0] ins);
        instr = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        while (mq[0].size() > 0) tick();
    endtask

    task automatic check_val(string tag, logic [15:0] o, logic [15:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    initial begin
        logic [15:0] saved;
        for (int i = 0; i < 8; i++) begin
            dp_r[i]  = 16'($urandom);
            exp_r[i] = dp_r[i];
        end
        dp_a = 16'h0000;
        dp_g = 16'h0000;
        exec_instr = 16'h0000;
        accepted = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_halted[d] = 1'b0;
            halt_arm[d] = 1'b0;
        end
        #2;
        do_reset();

        run1(16'h2BFB);
        tick();
        check_val("mvi_r2", dp_r[2], 16'hFFFB);
        run1(16'h1500);
        check_val("mv_r5", dp_r[5], 16'hFFFB);

        run1(16'h2407);
        run1(16'h4480);
        check_val("add_r1_r1", dp_r[1], 16'd14);

        instr = 16'h6200;
        instr_valid = 1'b1;
        tick();
        instr = 16'h1800;
        for (int i = 0; i < 3; i++) begin
            check_val("ir_hold", u1.ir_q, 16'h6200);
            tick();
        end
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check_val("mv_after_sub", dp_r[6], exp_r[0]);

        for (int i = 0; i < 400; i++) begin
            if (!instr_valid || accepted) begin
                instr = {3'($urandom_range(0, 6)), 13'($urandom)};
                instr_valid = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        instr_valid = 1'b0;
        while (mq[0].size() > 0 || mq[1].size() > 0) tick();

        instr = 16'hE000;
        instr_valid = 1'b1;
        tick();
        instr = 16'h2C01;
        for (int i = 0; i < 8; i++) tick();
        check_val("halted", 16'(hlt[1]), 16'd1);
        check_val("halt_ready", 16'(rdy[1]), 16'd0);

        do_reset();
        saved = dp_r[3];
        instr = 16'h8D80;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        do_reset();
        tick();
        check_val("abort_rx", dp_r[3], saved);
        run1(16'h2C01);
        check_val("mvi_after_abort", dp_r[3], 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
